// File: rtl/snoop_bus_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snoop_bus_controller_pkg
// Description : Shared types and constants for the snooping bus controller:
//               bus operation encoding, cache_hit_in response codes,
//               controller state encoding, default core count and a helper
//               that builds the L2 write-back address of a flushed line.
// Revision    : 1.0 - initial release
// ============================================================================
package snoop_bus_controller_pkg;

  localparam int DEFAULT_NUM_CORES = 2;

  typedef enum logic [1:0] {
    BUS_RD   = 2'b00,
    BUS_UPGR = 2'b01,
    BUS_RDX  = 2'b10,
    BUS_NON  = 2'b11
  } bus_op_e;

  // Status returned to the requesting core in cache_hit_in
  localparam logic [1:0] HIT_NONE   = 2'b00;
  localparam logic [1:0] HIT_SHARED = 2'b01;  // peer supplied (or RdX from L2)
  localparam logic [1:0] HIT_EXCL   = 2'b10;  // L2 supplied, no sharers

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_SNOOP   = 3'd2,
    ST_L2_RD   = 3'd3,
    ST_RESP    = 3'd4,
    ST_RELEASE = 3'd5
  } state_e;

  // A flushed line is written back using the flusher's tag and the
  // line offset bits of the address currently on the bus.
  function automatic logic [31:0] flush_addr(input logic [23:0] tag,
                                             input logic [31:0] addr);
    return {tag, addr[7:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/snoop_bus_controller_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. The search starts at the pointer and
//               wraps; when accept_i is high the pointer moves to the core
//               after the current winner, so that winner has lowest priority
//               in the next round.
// Ports       : clk, reset (async, active-high)
//               req_i    [N-1:0] request vector
//               accept_i         winner accepted, advance pointer
//               gnt_o    [N-1:0] one-hot winner (all-zero if no request)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req_i,
  input  logic         accept_i,
  output logic [N-1:0] gnt_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  int               cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr_q) + k) % N;
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (win_found) begin
      gnt_o = N'(1) << win_idx;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i && win_found) begin
      if (int'(win_idx) == N - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = win_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/snoop_bus_controller.sv
`default_nettype none
// ============================================================================
// Module      : snoop_bus_controller
// Description : Shared-bus controller for NUM_CORES snooping L1 caches.
//               Arbitrates round-robin, broadcasts the owner's operation to
//               all peers for one snoop cycle, writes back a flushed line to
//               L2, returns peer or L2 data to the owner and inserts a
//               grant-free RELEASE cycle between owners.
// Ports       : clk, reset (async, active-high)
//   req_core            per-core bus request
//   bus_operation_out   per-core requested op      (from L1)
//   bus_address_out     per-core requested address (from L1)
//   cache_hit_out, flush_out, bus_data_out,
//   data_to_L2, tag_to_L2  per-core snoop responses (from L1)
//   grant               one-hot bus ownership
//   bus_operation_in, bus_address_in  snoop broadcast (to L1)
//   bus_data_in, cache_hit_in          fill data / status (to L1)
//   l2_rd_req/addr/data/valid          L2 read handshake
//   l2_wr_en/addr/data                 L2 flush write
// Revision    : 1.0 - initial release
// ============================================================================
module snoop_bus_controller
  import snoop_bus_controller_pkg::*;
#(
  parameter int NUM_CORES = DEFAULT_NUM_CORES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CORES-1:0]         req_core,
  input  logic [NUM_CORES-1:0][1:0]    bus_operation_out,
  input  logic [NUM_CORES-1:0][31:0]   bus_address_out,
  input  logic [NUM_CORES-1:0]         cache_hit_out,
  input  logic [NUM_CORES-1:0]         flush_out,
  input  logic [NUM_CORES-1:0][31:0]   bus_data_out,
  input  logic [NUM_CORES-1:0][31:0]   data_to_L2,
  input  logic [NUM_CORES-1:0][23:0]   tag_to_L2,
  output logic [NUM_CORES-1:0]         grant,
  output logic [NUM_CORES-1:0][1:0]    bus_operation_in,
  output logic [NUM_CORES-1:0][31:0]   bus_address_in,
  output logic [NUM_CORES-1:0][31:0]   bus_data_in,
  output logic [NUM_CORES-1:0][1:0]    cache_hit_in,
  output logic                         l2_rd_req,
  output logic [31:0]                  l2_rd_addr,
  input  logic [31:0]                  l2_rd_data,
  input  logic                         l2_rd_valid,
  output logic                         l2_wr_en,
  output logic [31:0]                  l2_wr_addr,
  output logic [31:0]                  l2_wr_data
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  bus_op_e          op_q, op_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [1:0]       hit_q, hit_d;

  logic [NUM_CORES-1:0] arb_gnt;
  logic                 arb_accept;
  logic [IDX_W-1:0]     arb_idx;

  logic             peer_hit_any;
  logic [IDX_W-1:0] peer_hit_idx;
  logic             peer_flush_any;
  logic [IDX_W-1:0] peer_flush_idx;

  // --------------------------------------------------------------------------
  // Arbitration: only consulted while idle
  // --------------------------------------------------------------------------
  assign arb_accept = (state_q == ST_IDLE) && (|req_core);

  rr_arbiter #(
    .N     (NUM_CORES),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .clk      (clk),
    .reset    (reset),
    .req_i    (req_core),
    .accept_i (arb_accept),
    .gnt_o    (arb_gnt)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (arb_gnt[i]) begin
        arb_idx = IDX_W'(i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Snoop response priority: lowest-index peer wins. The owner is excluded
  // because it sees BusNoN during the snoop and never responds to itself.
  // Descending scan so the lowest index is the last (winning) assignment.
  // --------------------------------------------------------------------------
  always_comb begin
    peer_hit_any   = 1'b0;
    peer_hit_idx   = '0;
    peer_flush_any = 1'b0;
    peer_flush_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (IDX_W'(i) != owner_q) begin
        if (cache_hit_out[i]) begin
          peer_hit_any = 1'b1;
          peer_hit_idx = IDX_W'(i);
        end
        if (flush_out[i]) begin
          peer_flush_any = 1'b1;
          peer_flush_idx = IDX_W'(i);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and transaction registers
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    hit_d   = hit_q;

    case (state_q)
      ST_IDLE: begin
        if (|req_core) begin
          owner_d = arb_idx;
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        op_d   = bus_op_e'(bus_operation_out[owner_q]);
        addr_d = bus_address_out[owner_q];
        data_d = '0;
        hit_d  = HIT_NONE;
        if (bus_op_e'(bus_operation_out[owner_q]) == BUS_NON) begin
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_SNOOP;
        end
      end

      ST_SNOOP: begin
        if (op_q == BUS_UPGR) begin
          hit_d   = HIT_NONE;
          state_d = ST_RESP;
        end else if (peer_hit_any) begin
          data_d  = bus_data_out[peer_hit_idx];
          hit_d   = HIT_SHARED;
          state_d = ST_RESP;
        end else begin
          state_d = ST_L2_RD;
        end
      end

      ST_L2_RD: begin
        if (l2_rd_valid) begin
          data_d  = l2_rd_data;
          // RdX gets the line for writing, so it is never reported exclusive-clean
          hit_d   = (op_q == BUS_RD) ? HIT_EXCL : HIT_SHARED;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        state_d = ST_RELEASE;
      end

      ST_RELEASE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      op_q    <= BUS_NON;
      addr_q  <= '0;
      data_q  <= '0;
      hit_q   <= HIT_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      hit_q   <= hit_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs are decoded from registered state only, so the asynchronous
  // reset drives them to their idle values in the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    grant          = '0;
    bus_address_in = '0;
    bus_data_in    = '0;
    cache_hit_in   = '0;
    l2_rd_req      = 1'b0;
    l2_rd_addr     = '0;
    l2_wr_en       = 1'b0;
    l2_wr_addr     = '0;
    l2_wr_data     = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      bus_operation_in[i] = BUS_NON;
    end

    case (state_q)
      ST_GRANT: begin
        grant = NUM_CORES'(1) << owner_q;
      end

      ST_SNOOP: begin
        grant = NUM_CORES'(1) << owner_q;
        for (int i = 0; i < NUM_CORES; i++) begin
          if (IDX_W'(i) != owner_q) begin
            bus_operation_in[i] = op_q;
            bus_address_in[i]   = addr_q;
          end
        end
        if (peer_flush_any) begin
          l2_wr_en   = 1'b1;
          l2_wr_addr = flush_addr(tag_to_L2[peer_flush_idx], addr_q);
          l2_wr_data = data_to_L2[peer_flush_idx];
        end
      end

      ST_L2_RD: begin
        grant      = NUM_CORES'(1) << owner_q;
        l2_rd_req  = 1'b1;
        l2_rd_addr = addr_q;
      end

      ST_RESP: begin
        grant                 = NUM_CORES'(1) << owner_q;
        bus_data_in[owner_q]  = data_q;
        cache_hit_in[owner_q] = hit_q;
      end

      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_snoop_bus_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_snoop_bus_controller
// Description : Scoreboard bench for snoop_bus_controller (2 cores). Stimulus
//               pushes the expected bus tenure and L2 write records; a
//               monitor rebuilds each tenure from the outputs and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snoop_bus_controller;

  localparam int NC = 2;

  logic                  clk;
  logic                  reset;
  logic [NC-1:0]         req_core;
  logic [NC-1:0][1:0]    bus_operation_out;
  logic [NC-1:0][31:0]   bus_address_out;
  logic [NC-1:0]         cache_hit_out;
  logic [NC-1:0]         flush_out;
  logic [NC-1:0][31:0]   bus_data_out;
  logic [NC-1:0][31:0]   data_to_L2;
  logic [NC-1:0][23:0]   tag_to_L2;
  logic [NC-1:0]         grant;
  logic [NC-1:0][1:0]    bus_operation_in;
  logic [NC-1:0][31:0]   bus_address_in;
  logic [NC-1:0][31:0]   bus_data_in;
  logic [NC-1:0][1:0]    cache_hit_in;
  logic                  l2_rd_req;
  logic [31:0]           l2_rd_addr;
  logic [31:0]           l2_rd_data;
  logic                  l2_rd_valid;
  logic                  l2_wr_en;
  logic [31:0]           l2_wr_addr;
  logic [31:0]           l2_wr_data;

  // L2 read response: auto model plus a forced source for the reset test
  logic        mdl_valid, frc_valid;
  logic [31:0] mdl_data, frc_data;
  logic        l2_auto;
  logic [31:0] l2_resp;
  logic [31:0] exp_rd_addr;
  int          l2_cnt;

  assign l2_rd_valid = mdl_valid | frc_valid;
  assign l2_rd_data  = frc_valid ? frc_data : mdl_data;

  snoop_bus_controller #(.NUM_CORES(NC)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_core          (req_core),
    .bus_operation_out (bus_operation_out),
    .bus_address_out   (bus_address_out),
    .cache_hit_out     (cache_hit_out),
    .flush_out         (flush_out),
    .bus_data_out      (bus_data_out),
    .data_to_L2        (data_to_L2),
    .tag_to_L2         (tag_to_L2),
    .grant             (grant),
    .bus_operation_in  (bus_operation_in),
    .bus_address_in    (bus_address_in),
    .bus_data_in       (bus_data_in),
    .cache_hit_in      (cache_hit_in),
    .l2_rd_req         (l2_rd_req),
    .l2_rd_addr        (l2_rd_addr),
    .l2_rd_data        (l2_rd_data),
    .l2_rd_valid       (l2_rd_valid),
    .l2_wr_en          (l2_wr_en),
    .l2_wr_addr        (l2_wr_addr),
    .l2_wr_data        (l2_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // One bus tenure as seen from grant rise to grant fall
  typedef struct {
    int          core;
    int          len;
    logic [31:0] data;
    logic [1:0]  hit;
    int          hit_cyc;
    bit          l2rd;
    int          snoop_cnt;
    logic [1:0]  snoop_op;
    logic [31:0] snoop_addr;
  } txn_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  txn_t exp_q[$];
  wr_t  exp_wr_q[$];

  function automatic txn_t mk(input int c, input int len, input logic [31:0] d,
                              input logic [1:0] h, input int hc, input bit rd,
                              input logic [1:0] sop, input logic [31:0] sa);
    txn_t t;
    t.core = c; t.len = len; t.data = d; t.hit = h; t.hit_cyc = hc; t.l2rd = rd;
    t.snoop_cnt = 1; t.snoop_op = sop; t.snoop_addr = sa;
    return t;
  endfunction

  // ---------------------------------------------------------------- L2 model
  initial begin
    mdl_valid = 1'b0;
    mdl_data  = '0;
    l2_cnt    = 0;
    forever begin
      @(negedge clk);
      if (mdl_valid) begin
        mdl_valid = 1'b0;
        l2_cnt    = 0;
      end else if (l2_auto && l2_rd_req && !reset) begin
        l2_cnt++;
        if (l2_cnt == 3) begin
          chk("l2_rd_addr", l2_rd_addr, exp_rd_addr);
          mdl_valid = 1'b1;
          mdl_data  = l2_resp;
        end
      end
    end
  end

  // ----------------------------------------------------------------- monitor
  bit          in_ten, have_prev;
  int          free_cnt, cur;
  txn_t        obs;
  initial begin
    in_ten = 0; have_prev = 0; free_cnt = 0; cur = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_ten = 0; have_prev = 0; free_cnt = 0;
      end else begin
        if (l2_wr_en) begin
          if (exp_wr_q.size() == 0) begin
            chk("unexpected_l2_wr", 32'd1, 32'd0);
          end else begin
            wr_t w;
            w = exp_wr_q.pop_front();
            chk("l2_wr_addr", l2_wr_addr, w.addr);
            chk("l2_wr_data", l2_wr_data, w.data);
          end
        end
        if (grant != '0) begin
          if (!in_ten) begin
            chk("grant_onehot", 32'($countones(grant)), 32'd1);
            if (have_prev) chk("grant_free_gap_ge1", 32'(free_cnt >= 1), 32'd1);
            for (int j = 0; j < NC; j++) if (grant[j]) cur = j;
            in_ten = 1;
            obs = mk(cur, 0, '0, 2'b00, 0, 0, 2'b11, '0);
            obs.snoop_cnt = 0;
          end
          free_cnt = 0;
          obs.len++;
          if (l2_rd_req) obs.l2rd = 1;
          for (int j = 0; j < NC; j++) begin
            if (j != cur && bus_operation_in[j] != 2'b11) begin
              obs.snoop_cnt++;
              obs.snoop_op   = bus_operation_in[j];
              obs.snoop_addr = bus_address_in[j];
            end
          end
          if (cache_hit_in[cur] != 2'b00) obs.hit_cyc++;
          obs.data = bus_data_in[cur];
          obs.hit  = cache_hit_in[cur];
        end else begin
          free_cnt++;
          if (in_ten) begin
            txn_t e;
            in_ten    = 0;
            have_prev = 1;
            chk("release_cache_hit_in", 32'(cache_hit_in), 32'd0);
            if (exp_q.size() == 0) begin
              chk("unexpected_tenure", 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              chk("owner",       obs.core,       e.core);
              chk("tenure_len",  obs.len,        e.len);
              chk("resp_data",   obs.data,       e.data);
              chk("resp_hit",    obs.hit,        e.hit);
              chk("hit_cycles",  obs.hit_cyc,    e.hit_cyc);
              chk("l2_rd_seen",  obs.l2rd,       e.l2rd);
              chk("snoop_cnt",   obs.snoop_cnt,  e.snoop_cnt);
              chk("snoop_op",    obs.snoop_op,   e.snoop_op);
              chk("snoop_addr",  obs.snoop_addr, e.snoop_addr);
            end
          end
        end
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic wait_grant(input int c, output int n);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (grant[c]) begin
        n = k;
        break;
      end
    end
    if (n == 0) chk("grant_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (grant == '0) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("release_timeout", 32'd1, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_single(input int c, input logic [1:0] op, input logic [31:0] addr);
    int n;
    @(negedge clk);
    bus_operation_out[c] = op;
    bus_address_out[c]   = addr;
    req_core[c]          = 1'b1;
    wait_grant(c, n);
    chk("req_to_grant_latency", n, 32'd1);
    req_core[c] = 1'b0;
    wait_idle();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_grant"},       32'(grant),            32'd0);
    chk({tag, "_l2_rd_req"},   32'(l2_rd_req),        32'd0);
    chk({tag, "_l2_wr_en"},    32'(l2_wr_en),         32'd0);
    chk({tag, "_cache_hit"},   32'(cache_hit_in),     32'd0);
    chk({tag, "_bus_op_in"},   32'(bus_operation_in), 32'hF);
    chk({tag, "_addr_in"},     32'(|bus_address_in),  32'd0);
    chk({tag, "_data_in"},     32'(|bus_data_in),     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises;
    logic [NC-1:0] prev_g;
    reset = 1'b1;
    req_core = '0;
    bus_operation_out = {NC{2'b11}};
    bus_address_out = '0;
    cache_hit_out = '0; flush_out = '0;
    bus_data_out = '0; data_to_L2 = '0; tag_to_L2 = '0;
    frc_valid = 1'b0; frc_data = '0;
    l2_auto = 1'b1; l2_resp = '0; exp_rd_addr = '0;

    repeat (3) @(negedge clk);
    chk_idle_outputs("reset_state");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // T1: core0 BusRd, no peer hit, L2 answers 0xDEADBEEF on its 3rd wait cycle
    l2_resp = 32'hDEADBEEF; exp_rd_addr = 32'h0000_0104;
    exp_q.push_back(mk(0, 6, 32'hDEADBEEF, 2'b10, 1, 1, 2'b00, 32'h0000_0104));
    run_single(0, 2'b00, 32'h0000_0104);

    // T2: core1 BusRd, core0 hits and flushes
    cache_hit_out[0] = 1'b1; flush_out[0] = 1'b1;
    bus_data_out[0] = 32'h12345678; data_to_L2[0] = 32'h12345678;
    tag_to_L2[0] = 24'hABCDEF;
    exp_wr_q.push_back('{addr: 32'hABCDEF04, data: 32'h12345678});
    exp_q.push_back(mk(1, 3, 32'h12345678, 2'b01, 1, 0, 2'b00, 32'h0000_0104));
    run_single(1, 2'b00, 32'h0000_0104);
    cache_hit_out = '0; flush_out = '0; bus_data_out = '0; data_to_L2 = '0; tag_to_L2 = '0;

    // T4: both cores request continuously (BusUpgr) -> 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) exp_q.push_back(mk(0, 3, 32'd0, 2'b00, 0, 0, 2'b01, 32'h40));
      else            exp_q.push_back(mk(1, 3, 32'd0, 2'b00, 0, 0, 2'b01, 32'h80));
    end
    @(negedge clk);
    bus_operation_out[0] = 2'b01; bus_address_out[0] = 32'h40;
    bus_operation_out[1] = 2'b01; bus_address_out[1] = 32'h80;
    req_core = 2'b11;
    rises = 0; prev_g = '0;
    for (int k = 0; k < 100 && rises < 4; k++) begin
      @(negedge clk);
      if (grant != '0 && prev_g == '0) rises++;
      prev_g = grant;
    end
    chk("alternation_rises", rises, 32'd4);
    req_core = '0;
    wait_idle();

    // T3: core0 BusUpgr 0x40, grant gone 3 cycles after GRANT
    exp_q.push_back(mk(0, 3, 32'd0, 2'b00, 0, 0, 2'b01, 32'h40));
    run_single(0, 2'b01, 32'h40);

    // T5: reset while waiting in L2_RD; a late l2_rd_valid must be ignored
    l2_auto = 1'b0;
    @(negedge clk);
    bus_operation_out[0] = 2'b00; bus_address_out[0] = 32'h200;
    req_core[0] = 1'b1;
    begin
      int n;
      bit seen;
      wait_grant(0, n);
      req_core[0] = 1'b0;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (l2_rd_req) begin
          seen = 1;
          break;
        end
      end
      chk("reached_l2_rd", 32'(seen), 32'd1);
    end
    #2 reset = 1'b1;
    #1 chk_idle_outputs("async_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    frc_valid = 1'b1; frc_data = 32'hBADBAD00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_reset_grant",     32'(grant),        32'd0);
      chk("post_reset_l2_rd_req", 32'(l2_rd_req),    32'd0);
      chk("post_reset_hit",       32'(cache_hit_in), 32'd0);
      chk("post_reset_data",      32'(|bus_data_in), 32'd0);
    end
    frc_valid = 1'b0;
    repeat (3) @(negedge clk);

    chk("scoreboard_left", 32'(exp_q.size()), 32'd0);
    chk("l2_wr_left",      32'(exp_wr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/snoop_bus_controller.md
SNOOP_BUS_CONTROLLER -- requirements
Module: snoop_bus_controller

Interface
REQ-001 The block SHALL take parameter NUM_CORES, default 2, giving the number of L1 caches attached to the shared bus.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req_core, input, [NUM_CORES-1:0]: per-core bus request.
REQ-005 The block SHALL have ports bus_operation_out [NUM_CORES-1:0][1:0] and bus_address_out [NUM_CORES-1:0][31:0], inputs: per-core requested operation and address.
REQ-006 The block SHALL have ports cache_hit_out [NUM_CORES-1:0], flush_out [NUM_CORES-1:0], bus_data_out [NUM_CORES-1:0][31:0], data_to_L2 [NUM_CORES-1:0][31:0] and tag_to_L2 [NUM_CORES-1:0][23:0], inputs: per-core snoop responses.
REQ-007 The block SHALL have port grant, output, [NUM_CORES-1:0]: one-hot bus ownership.
REQ-008 The block SHALL have ports bus_operation_in [NUM_CORES-1:0][1:0] and bus_address_in [NUM_CORES-1:0][31:0], outputs: snoop broadcast.
REQ-009 The block SHALL have ports bus_data_in [NUM_CORES-1:0][31:0] and cache_hit_in [NUM_CORES-1:0][1:0], outputs: fill data and status to the requester.
REQ-010 The block SHALL have L2 ports l2_rd_req (output, 1), l2_rd_addr (output, 32), l2_rd_data (input, 32) and l2_rd_valid (input, 1): read handshake.
REQ-011 The block SHALL have L2 ports l2_wr_en (output, 1), l2_wr_addr (output, 32) and l2_wr_data (output, 32): flush write.

Function
REQ-012 Bus op encoding SHALL be BusRd=00, BusUpgr=01, BusRdX=10, BusNoN=11; cache_hit_in SHALL be 00 none, 01 shared (peer supplied), 10 exclusive (L2 supplied).
REQ-013 The FSM SHALL have states IDLE, GRANT, SNOOP, L2_RD, RESP and RELEASE.
REQ-014 IDLE: if any req_core bit is set, the block SHALL pick a winner round-robin, starting at the core after the last winner, and go to GRANT; otherwise it SHALL stay in IDLE.
REQ-015 GRANT: grant[w] SHALL be 1 (held through RESP), and the block SHALL latch op=bus_operation_out[w] and addr=bus_address_out[w]; if op=BusNoN it SHALL go to RELEASE, otherwise to SNOOP.
REQ-016 SNOOP: every core other than w SHALL see bus_operation_in=op and bus_address_in=addr for exactly one cycle; core w SHALL see BusNoN.
REQ-017 SNOOP flush: for any flushing core, the block SHALL assert l2_wr_en for that cycle with l2_wr_addr={tag_to_L2,addr[7:0]} and l2_wr_data=data_to_L2; if several cores flush, the lowest-index core wins.
REQ-018 SNOOP, op=BusUpgr: the block SHALL go to RESP with cache_hit_in[w]=00.
REQ-019 SNOOP, op=BusRd/BusRdX with any peer cache_hit_out: the block SHALL register the lowest-index hitter's bus_data_out into bus_data_in[w], set cache_hit_in[w]=01, and go to RESP.
REQ-020 SNOOP, BusRd/BusRdX with no peer hit: the block SHALL go to L2_RD.
REQ-021 L2_RD: l2_rd_req SHALL be 1 and l2_rd_addr=addr until l2_rd_valid; on valid the block SHALL capture l2_rd_data into bus_data_in[w], set cache_hit_in[w]=10 for BusRd or 01 for BusRdX, and go to RESP; there SHALL be no timeout.
REQ-022 RESP: bus_data_in[w] and cache_hit_in[w] SHALL be held for exactly one cycle, then the block SHALL go to RELEASE.
REQ-023 RELEASE: grant SHALL be 0 and cache_hit_in SHALL be 00, for one cycle, then the block SHALL go to IDLE; this guarantees at least one grant-free cycle between owners.
REQ-024 Outside SNOOP, all bus_operation_in lanes SHALL be BusNoN and all bus_address_in lanes 0.
REQ-025 A request from core w that is still asserted after RELEASE SHALL lose to any other pending core (fairness).
REQ-026 Request-to-grant latency SHALL be 1 cycle; a peer-hit transaction SHALL take 4 cycles from GRANT to RELEASE; an L2 transaction SHALL take 4 cycles plus the L2 wait.

Reset
REQ-027 On reset assertion, regardless of state, the block SHALL immediately force: state=IDLE, round-robin pointer=0, grant=0, bus_operation_in=BusNoN, all addresses and data 0, cache_hit_in=00, l2_rd_req=0, l2_wr_en=0.
REQ-028 A pending l2_rd_valid arriving after reset SHALL be ignored.

Structure
REQ-029 A shared package SHALL hold the bus op enum, the cache_hit code constants, the state enum and the NUM_CORES default.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (request vector in, one-hot grant out, pointer update on an accept strobe).

Verification
REQ-031 The bench SHALL cover: core0 BusRd 0x0000_0104, no peer hit, L2 returns 0xDEADBEEF after 3 cycles -> bus_data_in[0]=0xDEADBEEF, cache_hit_in[0]=10 for one cycle.
REQ-032 The bench SHALL cover: core1 BusRd 0x0000_0104, core0 hits with flush, data 0x12345678 -> l2_wr_en with l2_wr_data=0x12345678, bus_data_in[1]=0x12345678, cache_hit_in[1]=01, no l2_rd_req.
REQ-033 The bench SHALL cover: core0 BusUpgr 0x40 -> bus_operation_in[1]=01 for one SNOOP cycle, cache_hit_in[0]=00, grant released 3 cycles after GRANT.
REQ-034 The bench SHALL cover: both cores request continuously -> grants alternate 0,1,0,1 with one grant-free cycle between them.
REQ-035 The bench SHALL cover: reset asserted during L2_RD -> grant, l2_rd_req and all lanes at reset values in the same cycle; a later l2_rd_valid is ignored.
